// File: rtl/data_mem_bridge.sv
// Bridges the core's single-cycle load/store request onto a valid/ready data bus.
// Stalls the core while the access is outstanding and flags misaligned or timed-out accesses.
module data_mem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              bus_err,
    output logic              bus_valid,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic             err_flag;
    logic             err_nx;
    logic             req;
    logic             aligned;
    logic             expired;

    assign req     = cpu_we | cpu_re;
    assign aligned = (cpu_addr[1:0] == 2'b00);
    assign expired = (cnt == CNT_MAX);

    // Reset gating keeps stall low while the core is itself held in reset.
    assign stall   = rst & (((state == IDLE) & req) | (state == REQ));
    assign bus_err = err_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (aligned) begin
                        state_nx = REQ;
                    end else begin
                        state_nx = DONE;
                        err_nx   = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus_ready) begin
                    state_nx = DONE;
                end else if (expired) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            err_flag  <= 1'b0;
            cpu_rdata <= '0;
            bus_valid <= 1'b0;
            bus_write <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            err_flag <= err_nx;
            case (state)
                IDLE: begin
                    if (req) begin
                        bus_write <= cpu_we;
                        bus_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                        bus_wdata <= cpu_wdata;
                        bus_valid <= aligned;
                        cnt       <= '0;
                        if (!aligned && !cpu_we) begin
                            cpu_rdata <= '0;
                        end
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        if (!bus_write) begin
                            cpu_rdata <= bus_rdata;
                        end
                    end else if (expired) begin
                        bus_valid <= 1'b0;
                        if (!bus_write) begin
                            cpu_rdata <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench for data_mem_bridge: reads, writes, wait states, timeout,
// misalignment, mid-access reset and held request inputs across DONE.
module tb_data_mem_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        bus_err;
    logic        bus_valid;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int n_asserts = 0;
    int n_fails   = 0;

    data_mem_bridge #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_we   (cpu_we),
        .cpu_re   (cpu_re),
        .cpu_rdata(cpu_rdata),
        .stall    (stall),
        .bus_err  (bus_err),
        .bus_valid(bus_valid),
        .bus_write(bus_write),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ready(bus_ready),
        .bus_rdata(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request at posedge+1 and runs until the DONE cycle has passed.
    // The bus answers with ready after wait_n cycles of bus_valid when ready_en is set.
    task automatic run_access(input logic we, input logic re, input logic [31:0] addr,
                              input logic [31:0] wdata, input int wait_n, input logic ready_en,
                              input logic [31:0] rdata, output int n_stall, output int n_valid,
                              output logic err, output logic stable, output logic done);
        int cyc;
        logic [31:0] a0;
        logic [31:0] d0;
        n_stall = 0;
        n_valid = 0;
        err     = 1'b0;
        stable  = 1'b1;
        done    = 1'b0;
        cyc     = 0;
        a0      = '0;
        d0      = '0;
        cpu_we    = we;
        cpu_re    = re;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        bus_rdata = rdata;
        while (!done && cyc < 40) begin
            #1;
            if (stall) n_stall++;
            if (bus_valid) begin
                if (n_valid == 0) begin
                    a0 = bus_addr;
                    d0 = bus_wdata;
                end else if (bus_addr !== a0 || bus_wdata !== d0) begin
                    stable = 1'b0;
                end
                bus_ready = ready_en && (n_valid == wait_n);
                n_valid++;
            end else begin
                bus_ready = 1'b0;
            end
            if (cyc > 0 && !stall) begin
                done = 1'b1;
                err  = bus_err;
            end
            @(posedge clk);
            #1;
            cpu_we = 1'b0;
            cpu_re = 1'b0;
            bus_ready = 1'b0;
            cyc++;
        end
    endtask

    initial begin
        int   ns;
        int   nv;
        logic er;
        logic st;
        logic dn;

        rst       = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_we    = 1'b0;
        cpu_re    = 1'b1;
        bus_ready = 1'b0;
        bus_rdata = '0;
        #1;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_valid", {31'b0, bus_valid}, 32'd0);
        check("rst_err", {31'b0, bus_err}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        cpu_re = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Read with zero wait states
        run_access(1'b0, 1'b1, 32'h10, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, ns, nv, er, st, dn);
        check("rd0_done", {31'b0, dn}, 32'd1);
        check("rd0_stall", ns, 32'd2);
        check("rd0_valid", nv, 32'd1);
        check("rd0_err", {31'b0, er}, 32'd0);
        check("rd0_rdata", cpu_rdata, 32'hDEAD_BEEF);

        // Directed single-step check of the same timing: bus fields in REQ
        cpu_re = 1'b1;
        cpu_addr = 32'h0000_0010;
        #1;
        check("rd1_c0_stall", {31'b0, stall}, 32'd1);
        check("rd1_c0_valid", {31'b0, bus_valid}, 32'd0);
        @(posedge clk);
        #1;
        cpu_re = 1'b0;
        bus_ready = 1'b1;
        bus_rdata = 32'h0102_0304;
        check("rd1_c1_valid", {31'b0, bus_valid}, 32'd1);
        check("rd1_c1_write", {31'b0, bus_write}, 32'd0);
        check("rd1_c1_addr", bus_addr, 32'h10);
        check("rd1_c1_stall", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        bus_ready = 1'b0;
        check("rd1_c2_stall", {31'b0, stall}, 32'd0);
        check("rd1_c2_valid", {31'b0, bus_valid}, 32'd0);
        check("rd1_c2_rdata", cpu_rdata, 32'h0102_0304);
        @(posedge clk);
        #1;

        // Write with three wait states
        run_access(1'b1, 1'b0, 32'h20, 32'h1234_5678, 3, 1'b1, 32'hFFFF_FFFF, ns, nv, er, st, dn);
        check("wr3_done", {31'b0, dn}, 32'd1);
        check("wr3_valid", nv, 32'd4);
        check("wr3_stall", ns, 32'd5);
        check("wr3_stable", {31'b0, st}, 32'd1);
        check("wr3_err", {31'b0, er}, 32'd0);
        check("wr3_rdata", cpu_rdata, 32'h0102_0304);
        check("wr3_wdata", bus_wdata, 32'h1234_5678);
        check("wr3_addr", bus_addr, 32'h20);

        // Misaligned write: no bus transaction, error pulse
        run_access(1'b1, 1'b0, 32'h6, 32'hAAAA_5555, 0, 1'b1, 32'h0, ns, nv, er, st, dn);
        check("mis_done", {31'b0, dn}, 32'd1);
        check("mis_valid", nv, 32'd0);
        check("mis_stall", ns, 32'd1);
        check("mis_err", {31'b0, er}, 32'd1);
        check("mis_err_pulse", {31'b0, bus_err}, 32'd0);
        check("mis_rdata", cpu_rdata, 32'h0102_0304);

        // Reset pulled in the middle of a waiting read
        cpu_re = 1'b1;
        cpu_addr = 32'h40;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mrst_pre_valid", {31'b0, bus_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_valid", {31'b0, bus_valid}, 32'd0);
        check("mrst_stall", {31'b0, stall}, 32'd0);
        check("mrst_rdata", cpu_rdata, 32'd0);
        check("mrst_addr", bus_addr, 32'd0);
        check("mrst_err", {31'b0, bus_err}, 32'd0);
        cpu_re = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_access(1'b0, 1'b1, 32'h44, 32'h0, 1, 1'b1, 32'hCAFE_F00D, ns, nv, er, st, dn);
        check("post_done", {31'b0, dn}, 32'd1);
        check("post_stall", ns, 32'd3);
        check("post_valid", nv, 32'd2);
        check("post_rdata", cpu_rdata, 32'hCAFE_F00D);
        check("post_err", {31'b0, er}, 32'd0);

        // Read that never gets ready: timeout after TIMEOUT+1 valid cycles
        run_access(1'b0, 1'b1, 32'h30, 32'h0, 0, 1'b0, 32'h0, ns, nv, er, st, dn);
        check("to_done", {31'b0, dn}, 32'd1);
        check("to_valid", nv, 32'd5);
        check("to_stall", ns, 32'd6);
        check("to_err", {31'b0, er}, 32'd1);
        check("to_err_pulse", {31'b0, bus_err}, 32'd0);
        check("to_rdata", cpu_rdata, 32'd0);
        check("to_idle_stall", {31'b0, stall}, 32'd0);

        // we and re both held through DONE, then a read on the next instruction
        cpu_we = 1'b1;
        cpu_re = 1'b1;
        cpu_addr = 32'h50;
        cpu_wdata = 32'hA5A5_A5A5;
        #1;
        check("both_c0_stall", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        bus_ready = 1'b1;
        check("both_c1_valid", {31'b0, bus_valid}, 32'd1);
        check("both_c1_write", {31'b0, bus_write}, 32'd1);
        check("both_c1_wdata", bus_wdata, 32'hA5A5_A5A5);
        @(posedge clk);
        #1;
        bus_ready = 1'b0;
        check("both_c2_stall", {31'b0, stall}, 32'd0);
        check("both_c2_valid", {31'b0, bus_valid}, 32'd0);
        check("both_c2_rdata", cpu_rdata, 32'd0);
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
        cpu_re = 1'b1;
        cpu_addr = 32'h54;
        bus_rdata = 32'h0BAD_F00D;
        #1;
        check("both_c3_stall", {31'b0, stall}, 32'd1);
        check("both_c3_valid", {31'b0, bus_valid}, 32'd0);
        @(posedge clk);
        #1;
        cpu_re = 1'b0;
        bus_ready = 1'b1;
        check("both_c4_valid", {31'b0, bus_valid}, 32'd1);
        check("both_c4_write", {31'b0, bus_write}, 32'd0);
        check("both_c4_addr", bus_addr, 32'h54);
        @(posedge clk);
        #1;
        bus_ready = 1'b0;
        check("both_c5_rdata", cpu_rdata, 32'h0BAD_F00D);
        check("both_c5_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Sits directly downstream of the core datapath's load/store path. Accepts the single-cycle memory request the datapath produces (ALU result as address, RD2 as store data, write enable, read enable) and turns it into a valid/ready transaction on an external data bus with arbitrary wait states. Drives a stall back to the core so the PC and register file hold until the access completes. Also returns the load data and flags misaligned or timed-out accesses.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum REQ-state cycles without `bus_ready` before abort; must be ≥1
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- cpu_addr  input  ADDR_W  byte address (datapath ALU result)
- cpu_wdata  input  DATA_W  store data (datapath RD2)
- cpu_we  input  1  store request
- cpu_re  input  1  load request
- cpu_rdata  output  DATA_W  registered load data
- stall  output  1  hold core state this cycle
- bus_err  output  1  one-cycle error pulse
- bus_valid  output  1  bus request
- bus_write  output  1  1=write, 0=read
- bus_addr  output  ADDR_W  bus address, word-aligned
- bus_wdata  output  DATA_W  bus write data
- bus_ready  input  1  bus accepts/completes request this cycle
- bus_rdata  input  DATA_W  read data, valid in the `bus_ready` cycle

## Operation
- Three states: IDLE, REQ, DONE. Reset state is IDLE.
- IDLE
  - If `cpu_we|cpu_re`, latch the address, write data and op into internal regs; `cpu_we` wins if both are set.
  - `stall` is driven combinationally high in that same cycle.
  - Aligned access (`cpu_addr[1:0]==0`): go to REQ and clear the timeout counter.
  - Misaligned access: go to DONE with the error flag set. No bus transaction is issued.
  - No request: stay in IDLE with `stall`=0.
- REQ
  - `bus_valid`=1, with `bus_write`/`bus_addr`/`bus_wdata` taken from the latched regs. They are stable until the handshake.
  - `stall`=1.
  - `bus_ready`=1: the transaction completes. On a read, `cpu_rdata`←`bus_rdata`. Go to DONE.
  - Otherwise the counter increments. When the counter equals TIMEOUT with no `bus_ready`, go to DONE with the error flag set.
  - `bus_valid` drops on entry to DONE whether the access completed or aborted.
- DONE
  - `stall`=0, so the core retires the instruction this cycle.
  - `bus_err` = error flag.
  - On an errored read, `cpu_rdata` is set to 0 on entry to DONE.
  - CPU request inputs are ignored, because they still belong to the retiring instruction.
  - Unconditionally go to IDLE.
- `cpu_rdata` changes only on read completion or errored read, and otherwise holds. Writes never alter it.
- Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset (async, `rst`=0): state IDLE, `cpu_rdata`=0, `bus_valid`=0, `bus_write`=0, `bus_addr`=0, `bus_wdata`=0, `bus_err`=0, counter=0, error flag=0.
- `stall` during reset = 0, since the request is gated by the IDLE decode only after `rst` deasserts. The core is held by its own reset.
- Reset mid-REQ: `bus_valid` falls asynchronously. The bus must tolerate an abandoned request.
- Aligned access with `bus_ready` on the first REQ cycle:
  - Cycle 0: IDLE, `stall`=1.
  - Cycle 1: REQ, `bus_valid`=1, `bus_ready`=1.
  - Cycle 2: DONE, `stall`=0.
  - Total: 2 stall cycles per access.
- With N wait states, the access takes 2+N stall cycles.
- Misaligned access: 1 stall cycle, then DONE with `bus_err`=1.
- Timeout: `bus_valid` is high for exactly TIMEOUT+1 cycles, then DONE with `bus_err`=1.
- Back-to-back accesses: the next request is sampled in the IDLE cycle after DONE. The minimum access-to-access spacing is 3 cycles.
- All outputs except `stall` are registered. `stall` = (IDLE & (`cpu_we`|`cpu_re`)) | REQ.

## Test plan
- Read @0x0000_0010, `bus_ready` on the first REQ cycle, `bus_rdata`=0xDEAD_BEEF -> `stall` high for 2 cycles, `bus_write`=0, `bus_addr`=0x10; `cpu_rdata`=0xDEAD_BEEF in DONE; `bus_err`=0.
- Write 0x1234_5678 @0x20 with `bus_ready` delayed 3 cycles -> `bus_valid` high for 4 cycles with stable `bus_addr`/`bus_wdata`; `stall` 5 cycles; `cpu_rdata` unchanged.
- Read @0x30 with `bus_ready` held 0, TIMEOUT=4 -> `bus_valid` high 5 cycles, then `bus_err` pulses for 1 cycle; `cpu_rdata`=0; state returns to IDLE.
- Write @0x0000_0006 -> no `bus_valid`; `stall` 1 cycle; `bus_err` 1-cycle pulse.
- Read in REQ, `rst` pulled low mid-wait -> `bus_valid`=0 immediately and all outputs at reset values; after release, a new read completes normally.
- `cpu_we`=`cpu_re`=1 held through DONE, followed by a read on the next instruction -> first access is a write, no duplicate transaction in DONE, second access is a read issued from the following IDLE.
